// File: rtl/cbus_sram_responder_pkg.sv
// Shared cache-bus (cbus) request/response types and the responder's wait-counter width.
// All cbus agents agree on this package.
package cbus_sram_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
  typedef logic [3:0]  strobe_t;
  typedef logic [3:0]  mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [2:0]      size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Wide enough for the full 0..15 initial-wait range.
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/cbus_sram_responder_if.sv
// cbus request/response bundle between an initiator (master) and a responder (slave).
interface cbus_sram_responder_if;
  import cbus_sram_responder_pkg::*;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_sram_responder_array.sv
// Single-port word RAM: combinational read, byte-strobed synchronous write.
// Contents are never cleared.
module cbus_sram_array
  import cbus_sram_responder_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] idx,
  input  strobe_t              strobe,
  input  word_t                wdata,
  output word_t                rdata
);

  word_t mem [2**ADDR_BITS];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cbus_sram_responder.sv
// cbus responder backed by an on-chip SRAM: single-beat and FIXED/INCR/WRAP bursts
// after a fixed initial wait.
module cbus_sram_responder
  import cbus_sram_responder_pkg::*;
#(
  parameter int          ADDR_BITS   = 12,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_MASK   = 32'h0000_3fff
) (
  input logic                  clk,
  input logic                  resetn,
  cbus_sram_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_q, wait_nxt;
  mlen_t                 beat_q, beat_nxt;

  logic [ADDR_BITS-1:0]  idx_q, idx_step, wrap_mask;
  logic                  is_write_q;
  mlen_t                 len_q;
  axi_burst_type_t       burst_q;

  logic                  ready, last;
  word_t                 rdata;
  addr_t                 masked_addr;
  logic                  unused_req_bits;

  assign masked_addr = bus.creq.addr & BASE_MASK;
  // Byte offset, size and address bits outside the SRAM window never select anything.
  assign unused_req_bits = ^{masked_addr[31:ADDR_BITS+2], masked_addr[1:0], bus.creq.size};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
      beat_q <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_q;
    beat_nxt  = beat_q;
    ready     = 1'b0;
    last      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.creq.valid) begin
          wait_nxt  = WAIT_CNT_W'(WAIT_CYCLES);
          state_nxt = (WAIT_CYCLES == 0) ? BURST : WAIT;
        end
      end
      WAIT: begin
        if (!bus.creq.valid) begin
          state_nxt = IDLE;
          wait_nxt  = '0;
        end else begin
          wait_nxt = wait_q - 1'b1;
          if (wait_q == WAIT_CNT_W'(1)) state_nxt = BURST;
        end
      end
      BURST: begin
        // A dropped valid aborts without a handshake, so the beat is not written.
        if (!bus.creq.valid) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          ready = 1'b1;
          last  = (beat_q == len_q);
          if (last) begin
            state_nxt = IDLE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // WRAP keeps the upper index bits and wraps the low bits inside an aligned len+1 block.
  assign wrap_mask = ADDR_BITS'(len_q);

  always_comb begin
    idx_step = idx_q;
    case (burst_q)
      AXI_BURST_INCR: idx_step = idx_q + ADDR_BITS'(1);
      AXI_BURST_WRAP: idx_step = (idx_q & ~wrap_mask) | ((idx_q + ADDR_BITS'(1)) & wrap_mask);
      default:        idx_step = idx_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.creq.valid) begin
      idx_q      <= masked_addr[ADDR_BITS+1:2];
      is_write_q <= bus.creq.is_write;
      len_q      <= bus.creq.len;
      burst_q    <= bus.creq.burst;
    end else if (ready) begin
      idx_q <= idx_step;
    end
  end

  cbus_sram_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk    (clk),
    .we     (ready && is_write_q),
    .idx    (idx_q),
    .strobe (bus.creq.strobe),
    .wdata  (bus.creq.data),
    .rdata  (rdata)
  );

  assign bus.cresp.ready = ready;
  assign bus.cresp.last  = last;
  assign bus.cresp.data  = ready ? rdata : '0;

endmodule
